burst_sweep_bist: RTL and testbench

Built-in self-test sequencer for the (42,32) burst-4 error-correcting codec. It drives one message into the combinational encoder and registers the resulting codeword. It then walks every burst offset and every 4-bit error pattern, applying each corrupted codeword to the decoder and comparing the decoded message against the original. It sits beside the encoder/decoder pair and is the hardware replacement for the exhaustive simulation sweep.

---
 rtl/burst_sweep_bist.sv | 140 ++++++++++++++
 tb/tb_burst_sweep_bist.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/burst_sweep_bist.sv
// Exhaustive burst-error sweep for the (42,32) burst-4 codec: one message is encoded, then
// every burst offset and 4-bit pattern is applied to the decoder and the result is compared.
module burst_sweep_bist #(
  parameter int N = 42,
  parameter int K = 32,
  parameter int B = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           abort,
  input  logic [K-1:0]   msg_pattern,
  output logic [0:K-1]   enc_msg,
  input  logic [0:N-1]   enc_cw,
  output logic [0:N-1]   dec_cw,
  input  logic [0:K-1]   dec_msg,
  output logic           busy,
  output logic           done,
  output logic           result_valid,
  output logic           pass,
  output logic [15:0]    fail_count,
  output logic [5:0]     first_fail_offset,
  output logic [B-1:0]   first_fail_pattern
);

  localparam logic [5:0] LAST_OFFSET = 6'(N - B);

  typedef enum logic [2:0] {IDLE, LOAD, APPLY, CHECK, DONE} state_t;

  state_t         state;
  logic [0:N-1]   cw_reg;
  logic [0:N-1]   mask;
  logic [5:0]     offset;
  logic [B-1:0]   pattern;
  logic           mismatch;
  logic           last_vector;
  logic [15:0]    fail_next;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    // Index 0 is the leftmost bit of a [0:N-1] vector, so a right shift by offset moves
    // pattern[B-1] from index 0 to index offset, with the rest following in order.
    mask        = {pattern, {(N-B){1'b0}}} >> offset;
    mismatch    = (dec_msg != enc_msg);
    fail_next   = fail_count;
    if (mismatch && (fail_count != 16'hFFFF))
      fail_next = fail_count + 16'd1;
    last_vector = (offset == LAST_OFFSET) && (pattern == '1);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      enc_msg            <= '0;
      cw_reg             <= '0;
      dec_cw             <= '0;
      offset             <= '0;
      pattern            <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      result_valid       <= 1'b0;
      pass               <= 1'b0;
      fail_count         <= '0;
      first_fail_offset  <= '0;
      first_fail_pattern <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            // Positional copy: msg_pattern[K-1] lands in enc_msg[0].
            enc_msg            <= msg_pattern;
            fail_count         <= '0;
            first_fail_offset  <= '0;
            first_fail_pattern <= '0;
            result_valid       <= 1'b0;
            pass               <= 1'b0;
            offset             <= '0;
            pattern            <= '0;
            busy               <= 1'b1;
            state              <= LOAD;
          end else begin
            state <= IDLE;
          end
        end
        LOAD: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cw_reg <= enc_cw;
            state  <= APPLY;
          end
        end
        APPLY: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            dec_cw <= cw_reg ^ mask;
            state  <= CHECK;
          end
        end
        CHECK: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            fail_count <= fail_next;
            // The count never wraps, so zero means no failure has been recorded yet.
            if (mismatch && (fail_count == 16'd0)) begin
              first_fail_offset  <= offset;
              first_fail_pattern <= pattern;
            end
            if (pattern == '1) begin
              pattern <= '0;
              offset  <= offset + 6'd1;
            end else begin
              pattern <= pattern + 1'b1;
            end
            if (last_vector) begin
              busy         <= 1'b0;
              done         <= 1'b1;
              result_valid <= 1'b1;
              pass         <= (fail_next == 16'd0);
              state        <= DONE;
            end else begin
              state <= APPLY;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_burst_sweep_bist.sv
// Bench for burst_sweep_bist: models the codec (ideal, pass-through stub, inverting stub),
// runs table-driven sweeps through a scoreboard, and covers late start, abort and reset.
module tb_burst_sweep_bist;

  localparam int N = 42;
  localparam int K = 32;
  localparam int B = 4;

  logic           clk;
  logic           rst;
  logic           start;
  logic           abort;
  logic [K-1:0]   msg_pattern;
  logic [0:K-1]   enc_msg;
  logic [0:N-1]   enc_cw;
  logic [0:N-1]   dec_cw;
  logic [0:K-1]   dec_msg;
  logic           busy;
  logic           done;
  logic           result_valid;
  logic           pass;
  logic [15:0]    fail_count;
  logic [5:0]     first_fail_offset;
  logic [B-1:0]   first_fail_pattern;

  // Codec model: 0 = ideal burst-correcting decoder, 1 = pass-through of dec_cw[0:31],
  // 2 = always returns ~enc_msg.
  int mode;
  int passed;
  int total;

  burst_sweep_bist #(.N(N), .K(K), .B(B)) dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .abort              (abort),
    .msg_pattern        (msg_pattern),
    .enc_msg            (enc_msg),
    .enc_cw             (enc_cw),
    .dec_cw             (dec_cw),
    .dec_msg            (dec_msg),
    .busy               (busy),
    .done               (done),
    .result_valid       (result_valid),
    .pass               (pass),
    .fail_count         (fail_count),
    .first_fail_offset  (first_fail_offset),
    .first_fail_pattern (first_fail_pattern)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Systematic code: message in [0:31], folded parity in [32:41].
  function automatic logic [0:N-1] encode(input logic [0:K-1] m);
    logic [0:9] p;
    p = m[0:9] ^ m[10:19] ^ m[20:29] ^ {m[30:31], 8'h00};
    return {m, p};
  endfunction

  // True when every set bit of d lies inside one window of B consecutive indices.
  function automatic bit is_burst(input logic [0:N-1] d);
    logic [0:N-1] win;
    win = {{B{1'b1}}, {(N-B){1'b0}}};
    if (d == '0) return 1'b1;
    for (int o = 0; o <= N - B; o++)
      if ((d & (win >> o)) == d) return 1'b1;
    return 1'b0;
  endfunction

  logic [0:N-1] golden;
  assign enc_cw = encode(enc_msg);

  always_comb begin
    golden = encode(enc_msg);
    case (mode)
      0:       dec_msg = is_burst(dec_cw ^ golden) ? golden[0:K-1] : dec_cw[0:K-1];
      1:       dec_msg = dec_cw[0:K-1];
      default: dec_msg = ~enc_msg;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  typedef struct {
    int          mode;
    logic [31:0] msg;
    int          fails;
    int          off;
    int          pat;
    bit          pass_exp;
  } vec_t;

  vec_t vecs[6];
  vec_t sb[$];

  // Drive one sweep, push its expectation, then pop and compare at done.
  task automatic run_vec(input vec_t v);
    vec_t e;
    int   k;
    mode        = v.mode;
    msg_pattern = v.msg;
    sb.push_back(v);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    k = 1;
    check("busy_rise", 64'(busy), 64'd1);
    check("enc_msg_word", 64'(enc_msg), 64'(v.msg));
    check("enc_msg_bit0", 64'(enc_msg[0]), 64'(v.msg[31]));
    while (!done && k < 1400) begin
      @(negedge clk);
      k++;
    end
    check("done_latency", 64'(k), 64'd1250);
    e = sb.pop_front();
    check("fail_count", 64'(fail_count), 64'(e.fails));
    check("first_off", 64'(first_fail_offset), 64'(e.off));
    check("first_pat", 64'(first_fail_pattern), 64'(e.pat));
    check("pass", 64'(pass), 64'(e.pass_exp));
    check("rv_at_done", 64'(result_valid), 64'd1);
    check("busy_at_done", 64'(busy), 64'd0);
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);
    check("rv_hold", 64'(result_valid), 64'd1);
  endtask

  initial begin
    vec_t v;
    int   k;
    int   first_done;
    int   ndone;
    passed = 0;
    total  = 0;
    mode   = 0;
    start  = 1'b0;
    abort  = 1'b0;
    msg_pattern = '0;
    rst    = 1'b1;

    vecs[0] = '{0, 32'hFFFF_FFFF,   0, 0, 0, 1'b1};
    vecs[1] = '{1, 32'hFFFF_FFFF, 469, 0, 1, 1'b0};
    vecs[2] = '{0, 32'h0000_0000,   0, 0, 0, 1'b1};
    vecs[3] = '{2, 32'hFFFF_FFFF, 624, 0, 0, 1'b0};
    vecs[4] = '{0, 32'hA5C3_1E69,   0, 0, 0, 1'b1};
    vecs[5] = '{1, 32'h1234_5678, 469, 0, 1, 1'b0};

    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_rv", 64'(result_valid), 64'd0);
    check("rst_pass", 64'(pass), 64'd0);
    check("rst_fail_count", 64'(fail_count), 64'd0);
    check("rst_enc_msg", 64'(enc_msg), 64'd0);
    check("rst_dec_cw", 64'(dec_cw), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Second start mid-sweep must be ignored; exactly one done at 1250.
    mode = 0;
    msg_pattern = 32'h0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    first_done = 0;
    ndone = 0;
    for (k = 1; k <= 1300; k++) begin
      if (k > 1) @(negedge clk);
      start = (k == 600);
      if (done) begin
        ndone++;
        if (first_done == 0) first_done = k;
      end
    end
    start = 1'b0;
    check("late_start_ndone", 64'(ndone), 64'd1);
    check("late_start_latency", 64'(first_done), 64'd1250);
    check("late_start_fails", 64'(fail_count), 64'd0);

    // Abort during APPLY of vector 49 with the pass-through stub: 45 failures so far.
    mode = 1;
    msg_pattern = 32'hFFFF_FFFF;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (k = 2; k <= 100; k++) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_rv", 64'(result_valid), 64'd0);
    check("abort_partial_count", 64'(fail_count), 64'd45);
    check("abort_first_pat", 64'(first_fail_pattern), 64'd1);
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", 64'(ndone), 64'd0);
    v = '{0, 32'hFFFF_FFFF, 0, 0, 0, 1'b1};
    run_vec(v);

    // Asynchronous reset between edges in the middle of a sweep.
    mode = 1;
    msg_pattern = 32'hFFFF_FFFF;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (k = 2; k <= 500; k++) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_rv", 64'(result_valid), 64'd0);
    check("arst_fail_count", 64'(fail_count), 64'd0);
    check("arst_enc_msg", 64'(enc_msg), 64'd0);
    check("arst_dec_cw", 64'(dec_cw), 64'd0);
    check("arst_first_pat", 64'(first_fail_pattern), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    v = '{0, 32'hFFFF_FFFF, 0, 0, 0, 1'b1};
    run_vec(v);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
